conso_dyn_accu_multi: RTL



---
 rtl/conso_dyn_accu_multi_if.sv | 52 +++++
 rtl/conso_dyn_accu_multi.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/conso_dyn_accu_multi_if.sv
// Bus bundle for conso_dyn_accu_multi: monitored nets, window control,
// result read-back and the valid/ack handshake.
interface conso_dyn_accu_multi_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CAP_W = 8,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ACC_W = 40
);
    localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]       sig;
    logic [N_CH*CAP_W-1:0] cap_code;
    logic                  start;
    logic                  fin_test;
    logic                  rd_ack;
    logic [SEL_W-1:0]      ch_sel;
    logic [ACC_W-1:0]      internal_energy;
    logic [CNT_W-1:0]      ch_toggles;
    logic                  ovf;
    logic                  busy;
    logic                  valid;

    // Bench / consumer side
    modport master (
        output sig,
        output cap_code,
        output start,
        output fin_test,
        output rd_ack,
        output ch_sel,
        input  internal_energy,
        input  ch_toggles,
        input  ovf,
        input  busy,
        input  valid
    );

    // Monitor side
    modport slave (
        input  sig,
        input  cap_code,
        input  start,
        input  fin_test,
        input  rd_ack,
        input  ch_sel,
        output internal_energy,
        output ch_toggles,
        output ovf,
        output busy,
        output valid
    );
endinterface

// File: rtl/conso_dyn_accu_multi.sv
// Multi-net dynamic consumption monitor. Each edge on a watched net costs
// cap*K (K = V^2/2, or V^2 for rising-only mode); costs are summed into a
// saturating energy accumulator over a start/fin_test window, with per-net
// saturating toggle counters. Results are held until rd_ack / next start.
module conso_dyn_accu_multi #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned CAP_W     = 8,
    parameter int unsigned VSQ_HALF  = 720,
    parameter int unsigned EDGE_MODE = 0,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned ACC_W     = 40
) (
    input logic                   clk,
    input logic                   nrst,
    conso_dyn_accu_multi_if.slave bus
);
    localparam int unsigned SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned TERM_W = CAP_W + 17;
    localparam int unsigned SUM_W  = TERM_W + $clog2(N_CH);
    localparam int unsigned WIDE_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

    // Rising-only mode charges the full C*V^2 per rising edge.
    localparam logic [16:0] K_VAL = (EDGE_MODE != 0) ? 17'(2 * VSQ_HALF) : 17'(VSQ_HALF);

    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ACC_W-1:0]  ACC_MAX = {ACC_W{1'b1}};
    localparam logic [WIDE_W-1:0] ACC_MAX_WIDE = {{(WIDE_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } state_e;

    state_e state_q, state_d;
    logic   flush_q, flush_d;

    logic [N_CH-1:0]              hist_q;
    logic [N_CH-1:0][CAP_W-1:0]   cap_q;
    logic [N_CH-1:0][CAP_W-1:0]   cap_in;
    logic [N_CH-1:0][TERM_W-1:0]  term_q, term_d;
    logic [N_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]             acc_q, acc_d;
    logic                         ovf_q;

    logic [N_CH-1:0] hit;
    logic            sample;
    logic            cnt_ovf;
    logic            acc_ovf;
    logic [SUM_W-1:0]  term_sum;
    logic [WIDE_W-1:0] acc_wide;

    // FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
        end
    end

    // FSM next state: start always wins and restarts the window
    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        if (bus.start) begin
            state_d = StRun;
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StRun: begin
                    if (bus.fin_test) begin
                        state_d = StFlush;
                    end
                end
                StFlush: begin
                    // Two flush cycles drain the term stage and the accumulator add.
                    if (flush_q) begin
                        state_d = StDone;
                    end else begin
                        flush_d = 1'b1;
                    end
                end
                StDone: begin
                    if (bus.rd_ack) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Edge detection; a start cycle in RUN discards its edges since history is reloaded
    always_comb begin
        sample = (state_q == StRun) && !bus.start;
        hit    = '0;
        cap_in = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cap_in[i] = bus.cap_code[i*CAP_W +: CAP_W];
            if (EDGE_MODE != 0) begin
                hit[i] = sample & bus.sig[i] & ~hist_q[i];
            end else begin
                hit[i] = sample & (bus.sig[i] ^ hist_q[i]);
            end
        end
    end

    // Stage 1 next values: per-channel energy terms and saturating toggle counters
    always_comb begin
        term_d  = '0;
        cnt_d   = cnt_q;
        cnt_ovf = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (hit[i]) begin
                term_d[i] = TERM_W'(cap_q[i]) * TERM_W'(K_VAL);
                if (cnt_q[i] == CNT_MAX) begin
                    cnt_ovf = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Stage 2 next value: sum of terms added to the saturating accumulator
    always_comb begin
        term_sum = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            term_sum = term_sum + SUM_W'(term_q[i]);
        end
        acc_wide = WIDE_W'(acc_q) + WIDE_W'(term_sum);
        acc_ovf  = 1'b0;
        if (acc_wide > ACC_MAX_WIDE) begin
            acc_d   = ACC_MAX;
            acc_ovf = 1'b1;
        end else begin
            acc_d = acc_wide[ACC_W-1:0];
        end
    end

    // Edge history follows sig every cycle, so a start loads the current level
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hist_q <= '0;
        end else begin
            hist_q <= bus.sig;
        end
    end

    // Capacitance codes are frozen for the whole window at start
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cap_q <= '0;
        end else if (bus.start) begin
            cap_q <= cap_in;
        end
    end

    // Pipeline, counters and accumulator; start flushes anything in flight
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            term_q <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (bus.start) begin
            term_q <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            term_q <= term_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            ovf_q  <= ovf_q | cnt_ovf | acc_ovf;
        end
    end

    // Toggle count read-back; out-of-range selects read zero
    always_comb begin
        bus.ch_toggles = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (bus.ch_sel == SEL_W'(i)) begin
                bus.ch_toggles = cnt_q[i];
            end
        end
    end

    assign bus.internal_energy = acc_q;
    assign bus.ovf             = ovf_q;
    assign bus.busy            = (state_q == StRun) || (state_q == StFlush);
    assign bus.valid           = (state_q == StDone);

endmodule
